// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures memory words on Ready and
// holds up to two fetched instructions for decode, with stall and redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        IMemReady,
  input  logic [31:0] IMemRD,
  output logic [31:0] IMemAddr,
  input  logic        StallD,
  input  logic        RedirectD,
  input  logic [31:0] RedirectPC,
  output logic        ValidD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr0_q, instr0_d, instr1_q, instr1_d;
  logic [31:0] epc0_q, epc0_d, epc1_q, epc1_d;
  logic        consume_s;
  logic        accept_s;
  logic        unused_s;

  assign unused_s  = ^RedirectPC[1:0];
  assign consume_s = (state_q != EMPTY) && !StallD && !RedirectD;
  assign accept_s  = IMemReady && !RedirectD && ((state_q != FULL) || consume_s);

  // Next-state: redirect flushes; otherwise push at tail / pop from head (entry 0).
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr0_d = instr0_q;
    instr1_d = instr1_q;
    epc0_d   = epc0_q;
    epc1_d   = epc1_q;
    if (RedirectD) begin
      pc_d    = {RedirectPC[31:2], 2'b00};
      state_d = EMPTY;
    end else begin
      if (accept_s) begin
        pc_d = pc_q + PC_STEP;
      end else begin
        pc_d = pc_q;
      end
      case (state_q)
        EMPTY: begin
          if (accept_s) begin
            instr0_d = IMemRD;
            epc0_d   = pc_q;
            state_d  = ONE;
          end else begin
            state_d = EMPTY;
          end
        end
        ONE: begin
          if (accept_s && consume_s) begin
            instr0_d = IMemRD;
            epc0_d   = pc_q;
          end else if (accept_s) begin
            instr1_d = IMemRD;
            epc1_d   = pc_q;
            state_d  = FULL;
          end else if (consume_s) begin
            state_d = EMPTY;
          end else begin
            state_d = ONE;
          end
        end
        FULL: begin
          if (consume_s) begin
            instr0_d = instr1_q;
            epc0_d   = epc1_q;
            if (accept_s) begin
              instr1_d = IMemRD;
              epc1_d   = pc_q;
            end else begin
              state_d = ONE;
            end
          end else begin
            state_d = FULL;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State registers; Reset drops the buffer and PC immediately.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= EMPTY;
      pc_q     <= RESET_PC;
      instr0_q <= 32'h0;
      instr1_q <= 32'h0;
      epc0_q   <= 32'h0;
      epc1_q   <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr0_q <= instr0_d;
      instr1_q <= instr1_d;
      epc0_q   <= epc0_d;
      epc1_q   <= epc1_d;
    end
  end

  assign IMemAddr = {pc_q[31:2], 2'b00};
  assign ValidD   = (state_q != EMPTY);
  assign InstrD   = ValidD ? instr0_q : 32'h0;
  assign PCD      = ValidD ? epc0_q : 32'h0;
  assign PCPlus4D = ValidD ? (epc0_q + PC_STEP) : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model RAM[i] = 32'h1000_0000 + i.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        rst_w;
  logic        ready;
  logic        stall;
  logic        redir;
  logic [31:0] rpc;
  logic [31:0] addr, rd, instr, pcd, pcp4;
  logic        valid;
  logic [31:0] addr_w, rd_w, instr_w, pcd_w, pcp4_w;
  logic        valid_w;
  int          checks;
  int          errors;

  assign rd   = 32'h1000_0000 + {2'b00, addr[31:2]};
  assign rd_w = 32'h1000_0000 + {2'b00, addr_w[31:2]};

  fetch_unit u_dut (
    .CLK(clk), .Reset(rst), .IMemReady(ready), .IMemRD(rd), .IMemAddr(addr),
    .StallD(stall), .RedirectD(redir), .RedirectPC(rpc),
    .ValidD(valid), .InstrD(instr), .PCD(pcd), .PCPlus4D(pcp4)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .CLK(clk), .Reset(rst_w), .IMemReady(ready), .IMemRD(rd_w), .IMemAddr(addr_w),
    .StallD(stall), .RedirectD(redir), .RedirectPC(rpc),
    .ValidD(valid_w), .InstrD(instr_w), .PCD(pcd_w), .PCPlus4D(pcp4_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic d, input logic [31:0] p);
    ready = r;
    stall = s;
    redir = d;
    rpc   = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    rst_w  = 1'b1;
    ready  = 1'b0;
    stall  = 1'b0;
    redir  = 1'b0;
    rpc    = 32'h0;
    #12;
    check_eq("rst_valid", {31'd0, valid}, 32'd0);
    check_eq("rst_addr", addr, 32'h0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_pcd", pcd, 32'h0);
    check_eq("rst_pcp4", pcp4, 32'h0);
    check_eq("rst_addr_wrap", addr_w, 32'hFFFF_FFFC);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 32'h0);

    // Test 1: Ready every 4th cycle, no stall
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check_eq("t1_idle_valid", {31'd0, valid}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check_eq("t1_valid", {31'd0, valid}, 32'd1);
      check_eq("t1_instr", instr, 32'h1000_0000 + k);
      check_eq("t1_pcd", pcd, 32'(4 * k));
      check_eq("t1_pcp4", pcp4, 32'(4 * k + 4));
      check_eq("t1_addr", addr, 32'(4 * k + 4));
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("t1_one_cycle", {31'd0, valid}, 32'd0);

    // Test 2: stall 16 cycles, Ready every 4th
    step(1'b0, 1'b0, 1'b1, 32'h0);
    check_eq("t2_redir0_addr", addr, 32'h0);
    for (int i = 1; i <= 16; i++) begin
      step((i % 4) == 0, 1'b1, 1'b0, 32'h0);
      if (i >= 8) check_eq("t2_addr_held", addr, 32'h8);
    end
    check_eq("t2_valid", {31'd0, valid}, 32'd1);
    check_eq("t2_head", instr, 32'h1000_0000);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("t2_second", instr, 32'h1000_0001);
    check_eq("t2_second_pcd", pcd, 32'h4);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("t2_drained", {31'd0, valid}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("t2_third", instr, 32'h1000_0002);
    check_eq("t2_third_pcd", pcd, 32'h8);

    // Test 3: redirect coincident with Ready at 0x8
    step(1'b0, 1'b0, 1'b1, 32'h8);
    check_eq("t3_pre_addr", addr, 32'h8);
    step(1'b1, 1'b0, 1'b1, 32'h40);
    check_eq("t3_valid", {31'd0, valid}, 32'd0);
    check_eq("t3_addr", addr, 32'h40);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("t3_still_empty", {31'd0, valid}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("t3_instr", instr, 32'h1000_0010);
    check_eq("t3_pcd", pcd, 32'h40);
    check_eq("t3_pcp4", pcp4, 32'h44);

    // Test 4: unaligned redirect while FULL and stalled
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("t4_full_head", instr, 32'h1000_0010);
    check_eq("t4_full_addr", addr, 32'h48);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("t4_refused_addr", addr, 32'h48);
    step(1'b0, 1'b1, 1'b1, 32'h43);
    check_eq("t4_valid", {31'd0, valid}, 32'd0);
    check_eq("t4_addr", addr, 32'h40);
    check_eq("t4_instr", instr, 32'h0);
    check_eq("t4_pcd", pcd, 32'h0);

    // Test 5: async reset between edges with buffer FULL
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("t5_full_addr", addr, 32'h48);
    check_eq("t5_full_valid", {31'd0, valid}, 32'd1);
    ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("t5_async_valid", {31'd0, valid}, 32'd0);
    check_eq("t5_async_addr", addr, 32'h0);
    check_eq("t5_async_instr", instr, 32'h0);
    #2;
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("t5_after_valid", {31'd0, valid}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("t5_first_instr", instr, 32'h1000_0000);
    check_eq("t5_first_pcd", pcd, 32'h0);

    // Test 6: PC wrap from 0xFFFF_FFFC
    step(1'b0, 1'b0, 1'b0, 32'h0);
    rst_w = 1'b0;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("t6_pre_addr", addr_w, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("t6_valid", {31'd0, valid_w}, 32'd1);
    check_eq("t6_instr", instr_w, 32'h4FFF_FFFF);
    check_eq("t6_pcd", pcd_w, 32'hFFFF_FFFC);
    check_eq("t6_pcp4", pcp4_w, 32'h0);
    check_eq("t6_addr", addr_w, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
